// File: rtl/gate_signature_analyzer_if.sv
`default_nettype none
// =============================================================================
// gate_signature_analyzer_if : start/response handshake and result bundle
//   Optional golden/pass/fail signals exist only when GOLDEN_CMP_EN is defined.
// Revision: 1.0
// =============================================================================
interface gate_signature_analyzer_if;
  logic        start;
  logic [15:0] num_vec;
  logic        resp_valid;
  logic [9:0]  resp;
  logic        resp_ready;
  logic        busy;
  logic        done;
  logic [15:0] signature;
  logic [15:0] vec_cnt;
`ifdef GOLDEN_CMP_EN
  logic [15:0] golden;
  logic        pass;
  logic        fail;

  modport master (
    output start, num_vec, resp_valid, resp, golden,
    input  resp_ready, busy, done, signature, vec_cnt, pass, fail
  );
  modport slave (
    input  start, num_vec, resp_valid, resp, golden,
    output resp_ready, busy, done, signature, vec_cnt, pass, fail
  );
`else
  modport master (
    output start, num_vec, resp_valid, resp,
    input  resp_ready, busy, done, signature, vec_cnt
  );
  modport slave (
    input  start, num_vec, resp_valid, resp,
    output resp_ready, busy, done, signature, vec_cnt
  );
`endif
endinterface
`default_nettype wire

// File: rtl/gate_signature_analyzer.sv
`default_nettype none
// =============================================================================
// gate_signature_analyzer : 16-bit MISR compactor for 10-bit gate-model outputs
//   Optional golden compare with pass/fail verdict under macro GOLDEN_CMP_EN.
// Revision: 1.0
// =============================================================================
module gate_signature_analyzer #(
  parameter logic [15:0] SEED = 16'hFFFF,
  parameter logic [15:0] POLY = 16'h1021
) (
  input  wire logic           clk,
  input  wire logic           rst,
  gate_signature_analyzer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] sig_q, sig_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] nv_q, nv_d;
  logic        start_acc;
  logic        xfer;

  assign start_acc = (state_q == IDLE) && bus.start;
  assign xfer      = (state_q == CAPTURE) && bus.resp_valid;

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    nv_d    = nv_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          nv_d    = bus.num_vec;
          sig_d   = SEED;
          cnt_d   = 16'd0;
          state_d = (bus.num_vec == 16'd0) ? DONE : CAPTURE;
        end
      end
      CAPTURE: begin
        if (xfer) begin
          sig_d = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? POLY : 16'h0000) ^ {6'b0, bus.resp};
          cnt_d = cnt_q + 16'd1;
          // nv_q is non-zero here, so nv_q - 1 cannot underflow
          if (cnt_q == nv_q - 16'd1) begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sig_q   <= SEED;
      cnt_q   <= 16'd0;
      nv_q    <= 16'd0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      nv_q    <= nv_d;
    end
  end

  assign bus.resp_ready = (state_q == CAPTURE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == DONE);
  assign bus.signature  = sig_q;
  assign bus.vec_cnt    = cnt_q;

`ifdef GOLDEN_CMP_EN
  logic pass_q, pass_d;
  logic fail_q, fail_d;

  // Verdict is taken from the final signature while in DONE
  always_comb begin
    pass_d = pass_q;
    fail_d = fail_q;
    if (start_acc) begin
      pass_d = 1'b0;
      fail_d = 1'b0;
    end else if (state_q == DONE) begin
      pass_d = (sig_q == bus.golden);
      fail_d = (sig_q != bus.golden);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pass_q <= 1'b0;
      fail_q <= 1'b0;
    end else begin
      pass_q <= pass_d;
      fail_q <= fail_d;
    end
  end

  assign bus.pass = pass_q;
  assign bus.fail = fail_q;
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gate_signature_analyzer.sv
`default_nettype none
// =============================================================================
// tb_gate_signature_analyzer : table-driven, scoreboarded bench; two DUTs
//   (SEED = 0 and default SEED) share one stimulus stream.
// Revision: 1.0
// =============================================================================
module tb_gate_signature_analyzer;

  localparam logic [15:0] POLY = 16'h1021;

  typedef struct {
    logic [15:0] nv;
    logic [9:0]  r;
    logic [31:0] mask;
    int          mlen;
    logic [15:0] exp_sig0;
    logic [15:0] golden;
  } vec_t;

  typedef struct {
    logic [15:0] sig0;
    logic [15:0] sig1;
    logic [15:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   fails  = 0;
  exp_t sb[$];
  vec_t tab[6];

  always #5 clk = ~clk;

  gate_signature_analyzer_if a ();
  gate_signature_analyzer_if b ();

  assign b.start      = a.start;
  assign b.num_vec    = a.num_vec;
  assign b.resp_valid = a.resp_valid;
  assign b.resp       = a.resp;
`ifdef GOLDEN_CMP_EN
  assign b.golden     = a.golden;
`endif

  gate_signature_analyzer #(.SEED(16'h0000), .POLY(POLY)) dut0 (.clk(clk), .rst(rst), .bus(a));
  gate_signature_analyzer dut1 (.clk(clk), .rst(rst), .bus(b));

  function automatic logic [15:0] model(input logic [15:0] s0, input logic [9:0] r, input logic [15:0] n);
    logic [15:0] s;
    s = s0;
    for (int i = 0; i < int'(n); i++)
      s = {s[14:0], 1'b0} ^ (s[15] ? POLY : 16'h0000) ^ {6'b0, r};
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    int   cyc;
    int   stalls;
    int   busy_n;
    bit   vld;
    e.sig0 = v.exp_sig0;
    e.sig1 = model(16'hFFFF, v.r, v.nv);
    e.cnt  = v.nv;
    sb.push_back(e);
`ifdef GOLDEN_CMP_EN
    a.golden = v.golden;
`endif
    @(negedge clk);
    a.start   = 1'b1;
    a.num_vec = v.nv;
    @(negedge clk);
    a.start = 1'b0;
    cyc = 0; stalls = 0; busy_n = 0;
    while (!a.done && cyc < 400) begin
      busy_n += int'(a.busy);
      vld = v.mask[cyc % v.mlen];
      a.resp_valid = vld;
      a.resp       = v.r;
      if (!vld) stalls++;
      cyc++;
      @(negedge clk);
    end
    a.resp_valid = 1'b0;
    e = sb.pop_front();
    if (!a.done) begin
      checks++;
      fails++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", cyc);
      return;
    end
    busy_n += int'(a.busy);
    check("sig_seed0",   32'(a.signature), 32'(e.sig0));
    check("sig_seedff",  32'(b.signature), 32'(e.sig1));
    check("vec_cnt",     32'(a.vec_cnt),   32'(e.cnt));
    check("busy_cycles", 32'(busy_n),      32'(int'(v.nv) + stalls + 1));
    check("ready_in_done", 32'(a.resp_ready), 32'd0);
    @(negedge clk);
    check("done_pulse", 32'(a.done), 32'd0);
    check("busy_after", 32'(a.busy), 32'd0);
    check("sig_hold",   32'(a.signature), 32'(e.sig0));
`ifdef GOLDEN_CMP_EN
    check("pass0", 32'(a.pass), 32'(e.sig0 == v.golden));
    check("fail0", 32'(a.fail), 32'(e.sig0 != v.golden));
    check("pass1", 32'(b.pass), 32'(e.sig1 == v.golden));
`endif
  endtask

  initial begin
    // valid patterns are consumed LSB first, wrapping every mlen cycles
    tab[0] = '{16'd1,  10'h001, 32'h1,        1, 16'h0001, 16'h0001};
    tab[1] = '{16'd2,  10'h001, 32'h1,        1, 16'h0003, 16'h0003};
    tab[2] = '{16'd2,  10'h001, 32'h1,        1, 16'h0003, 16'h0004};
    tab[3] = '{16'd3,  10'h3FF, 32'b101001,   6, 16'h0BFD, 16'h0000};
    tab[4] = '{16'd0,  10'h000, 32'h1,        1, 16'h0000, 16'h0000};
    tab[5] = '{16'd4,  10'h2A5, 32'b110,      3, 16'h1853, 16'h1853};

    a.start = 1'b0; a.num_vec = 16'd0; a.resp_valid = 1'b0; a.resp = 10'd0;
`ifdef GOLDEN_CMP_EN
    a.golden = 16'd0;
`endif
    repeat (3) @(negedge clk);
    check("rst_sig0",  32'(a.signature),  32'h0000);
    check("rst_sig1",  32'(b.signature),  32'hFFFF);
    check("rst_cnt",   32'(a.vec_cnt),    32'd0);
    check("rst_busy",  32'(a.busy),       32'd0);
    check("rst_done",  32'(a.done),       32'd0);
    check("rst_ready", 32'(a.resp_ready), 32'd0);
`ifdef GOLDEN_CMP_EN
    check("rst_pass", 32'(a.pass), 32'd0);
    check("rst_fail", 32'(a.fail), 32'd0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(tab[i]);

    // long run so the feedback taps are exercised
    begin
      vec_t v;
      v = '{16'd40, 10'h155, 32'b1011, 4, 16'h0000, 16'h0000};
      v.exp_sig0 = model(16'h0000, 10'h155, 16'd40);
      run_vec(v);
    end

    // ignored start mid-run, then abort with rst after 2 of 5 vectors
    @(negedge clk);
    a.start = 1'b1; a.num_vec = 16'd5;
    @(negedge clk);
    a.start = 1'b0; a.resp_valid = 1'b1; a.resp = 10'h001;
    @(negedge clk);
    a.start = 1'b1; a.num_vec = 16'd2;
    @(negedge clk);
    a.start = 1'b0; a.resp_valid = 1'b0;
    check("mid_cnt",   32'(a.vec_cnt),    32'd2);
    check("mid_sig",   32'(a.signature),  32'h0003);
    check("mid_busy",  32'(a.busy),       32'd1);
    check("mid_done",  32'(a.done),       32'd0);
    check("mid_ready", 32'(a.resp_ready), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_sig0", 32'(a.signature), 32'h0000);
    check("abort_sig1", 32'(b.signature), 32'hFFFF);
    check("abort_cnt",  32'(a.vec_cnt),   32'd0);
    check("abort_busy", 32'(a.busy),      32'd0);
    check("abort_done", 32'(a.done),      32'd0);
    @(negedge clk);
    check("abort_done2", 32'(a.done), 32'd0);

    run_vec(tab[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
